spi_tx_scheduler: RTL and testbench

//  Shares one N-bit SPI master between NUM_REQ requesters using round-robin arbitration.
//  - Latches the winner's data and drives that requester's active-low chip select.
//  - Pulses the master's start input once, then waits for the master's done pulse.
//  - Acknowledges the requester and enforces an inter-frame CS gap.
//  - Sits between the SPI master and the client logic (sensor/config writers).

---
 rtl/spi_sched_pkg.sv | 15 +
 rtl/spi_tx_scheduler_arb.sv | 27 ++
 rtl/spi_tx_scheduler.sv | 172 +++++++++++++++++
 tb/tb_spi_tx_scheduler.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_sched_pkg.sv
// Shared types and default sizes for the SPI transmit scheduler.
package spi_sched_pkg;

  localparam int unsigned N_DEF       = 8;
  localparam int unsigned NUM_REQ_DEF = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    WAIT   = 3'd2,
    FINISH = 3'd3,
    GAP    = 3'd4
  } state_t;

endpackage

// File: rtl/spi_tx_scheduler_arb.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter
  import spi_sched_pkg::*;
#(
  parameter  int unsigned NUM_REQ = NUM_REQ_DEF,
  localparam int unsigned PW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic               valid,
  output logic [PW-1:0]      sel
);

  logic [PW-1:0] idx;

  // Scan from the farthest offset down so the nearest hit is assigned last.
  always_comb begin
    valid = |req;
    sel   = ptr;
    idx   = ptr;
    for (int unsigned off = NUM_REQ; off > 0; off--) begin
      idx = PW'((32'(ptr) + off - 32'd1) % NUM_REQ);
      if (req[idx]) sel = idx;
    end
  end

endmodule

// File: rtl/spi_tx_scheduler.sv
// Round-robin scheduler sharing one SPI master between NUM_REQ requesters.
// Optional WAIT-state timeout with err pulse when SPI_TIMEOUT_EN is defined.
module spi_tx_scheduler
  import spi_sched_pkg::*;
#(
  parameter int unsigned N       = N_DEF,
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned CS_GAP  = 2,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*N-1:0] req_data,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   ack,
  output logic [NUM_REQ-1:0]   cs_n,
  output logic [N-1:0]         mst_data,
  output logic                 mst_start,
  input  logic                 mst_done,
  output logic                 busy,
  output logic                 err
);

  localparam int unsigned PW   = $clog2(NUM_REQ);
  localparam int unsigned CMAX = (CS_GAP > TIMEOUT) ? CS_GAP : TIMEOUT;
  localparam int unsigned CW   = $clog2(CMAX + 1);

  state_t              state_q, state_d;
  logic [PW-1:0]       sel_q, sel_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [N-1:0]        data_q, data_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                to_d;

  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic [NUM_REQ-1:0]  cs_n_q, cs_n_d;
  logic                start_q, start_d;
  logic                busy_q, busy_d;

  logic                arb_valid;
  logic [PW-1:0]       arb_sel;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req   (req),
    .ptr   (ptr_q),
    .valid (arb_valid),
    .sel   (arb_sel)
  );

  // State, pointer, data latch and shared gap/timeout counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    to_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          sel_d = arb_sel;
          for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (arb_sel == PW'(i)) data_d = req_data[i*N +: N];
          end
          state_d = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (mst_done) begin
          state_d = FINISH;
        end
`ifdef SPI_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          to_d    = 1'b1;
          state_d = FINISH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      FINISH: begin
        ptr_d = (sel_q == PW'(NUM_REQ - 1)) ? '0 : sel_q + PW'(1);
        cnt_d = '0;
        if (CS_GAP > 0) state_d = GAP;
        else            state_d = IDLE;
      end
      GAP: begin
        if (cnt_q == CW'(CS_GAP - 1)) state_d = IDLE;
        else                          cnt_d   = cnt_q + CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the next state so they register in step with it.
  always_comb begin
    gnt_d   = '0;
    ack_d   = '0;
    cs_n_d  = '1;
    start_d = 1'b0;
    busy_d  = (state_d != IDLE);
    case (state_d)
      START: begin
        gnt_d[sel_d]  = 1'b1;
        cs_n_d[sel_d] = 1'b0;
        start_d       = 1'b1;
      end
      WAIT:    cs_n_d[sel_d] = 1'b0;
      FINISH:  if (!to_d) ack_d[sel_d] = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt_q   <= '0;
      ack_q   <= '0;
      cs_n_q  <= '1;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      cs_n_q  <= cs_n_d;
      start_q <= start_d;
      busy_q  <= busy_d;
    end
  end

`ifdef SPI_TIMEOUT_EN
  logic err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= to_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign gnt       = gnt_q;
  assign ack       = ack_q;
  assign cs_n      = cs_n_q;
  assign mst_start = start_q;
  assign busy      = busy_q;
  assign mst_data  = data_q;

endmodule

// File: tb/tb_spi_tx_scheduler.sv
// Directed bench for spi_tx_scheduler with a behavioural 8-bit SPI master.
module tb_spi_tx_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req, req2;
  logic [31:0] req_data;
  logic [3:0]  gnt, ack, cs_n, gnt2, ack2, cs_n2;
  logic [7:0]  mst_data, mst_data2;
  logic        mst_start, mst_done, busy, err;
  logic        mst_start2, mst_done2, busy2, err2;

  int   n_assert = 0;
  int   n_fail   = 0;
  logic err_seen = 1'b0;

  always #5 clk = ~clk;

  spi_tx_scheduler #(.N(8), .NUM_REQ(4), .CS_GAP(2)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data),
    .gnt(gnt), .ack(ack), .cs_n(cs_n), .mst_data(mst_data),
    .mst_start(mst_start), .mst_done(mst_done), .busy(busy), .err(err)
  );

  spi_tx_scheduler #(.N(8), .NUM_REQ(4), .CS_GAP(0)) dut2 (
    .clk(clk), .reset(reset), .req(req2), .req_data(req_data),
    .gnt(gnt2), .ack(ack2), .cs_n(cs_n2), .mst_data(mst_data2),
    .mst_start(mst_start2), .mst_done(mst_done2), .busy(busy2), .err(err2)
  );

  // Reference master: load on start, shift 8 bits MSB-first, then pulse done.
  logic [7:0] sh, rx;
  int         bits;
  logic       act;
  logic       mosi;
  assign mosi = sh[7];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      act <= 1'b0; bits <= 0; sh <= '0; rx <= '0; mst_done <= 1'b0;
    end else begin
      mst_done <= 1'b0;
      if (!act && mst_start) begin
        sh <= mst_data; rx <= '0; bits <= 8; act <= 1'b1;
      end else if (act && bits > 0) begin
        rx <= {rx[6:0], mosi}; sh <= {sh[6:0], 1'b0}; bits <= bits - 1;
      end else if (act) begin
        mst_done <= 1'b1; act <= 1'b0;
      end
    end
  end

  // Second master: same done timing, no shifting.
  int d2;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      d2 <= 0; mst_done2 <= 1'b0;
    end else begin
      mst_done2 <= 1'b0;
      if (mst_start2)   d2 <= 9;
      else if (d2 > 1)  d2 <= d2 - 1;
      else if (d2 == 1) begin d2 <= 0; mst_done2 <= 1'b1; end
    end
  end

  always @(posedge clk) if (err === 1'b1) err_seen <= 1'b1;

`ifdef SPI_TIMEOUT_EN
  logic [3:0] req3, gnt3, ack3, cs_n3;
  logic [7:0] mst_data3;
  logic       mst_start3, busy3, err3;
  logic       mst_done3 = 1'b0;
  spi_tx_scheduler #(.N(8), .NUM_REQ(4), .CS_GAP(2), .TIMEOUT(16)) dut3 (
    .clk(clk), .reset(reset), .req(req3), .req_data(req_data),
    .gnt(gnt3), .ack(ack3), .cs_n(cs_n3), .mst_data(mst_data3),
    .mst_start(mst_start3), .mst_done(mst_done3), .busy(busy3), .err(err3)
  );
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called on the mst_start cycle; returns cycles until ack and whether cs_n/data wavered.
  task automatic wait_ack1(input logic [3:0] cs_exp, input logic [7:0] d_exp,
                           output int cyc, output logic bad);
    cyc = 0; bad = 1'b0;
    do begin
      @(negedge clk); cyc++;
      if (ack === 4'b0 && (cs_n !== cs_exp || mst_data !== d_exp)) bad = 1'b1;
    end while (ack === 4'b0 && cyc < 100);
  endtask

  // Called on the ack cycle; returns cycles until the next gnt and whether any cs_n went low.
  task automatic wait_gnt1(output int cyc, output logic bad);
    cyc = 0; bad = 1'b0;
    do begin
      @(negedge clk); cyc++;
      if (gnt === 4'b0 && cs_n !== 4'hF) bad = 1'b1;
    end while (gnt === 4'b0 && cyc < 100);
  endtask

  initial begin
    int         cyc;
    logic       bad, seen;
    logic [3:0] oh;
    logic [7:0] exp_b;

    reset = 1'b1; req = '0; req2 = '0;
`ifdef SPI_TIMEOUT_EN
    req3 = '0;
`endif
    req_data = {8'h3C, 8'h96, 8'h5A, 8'hA5};
    repeat (3) @(negedge clk);

    chk("rst_cs_n",  32'(cs_n), 32'hF);
    chk("rst_gnt",   32'(gnt), 32'h0);
    chk("rst_ack",   32'(ack), 32'h0);
    chk("rst_busy",  32'(busy), 32'h0);
    chk("rst_start", 32'(mst_start), 32'h0);
    chk("rst_data",  32'(mst_data), 32'h0);
    chk("rst_err",   32'(err), 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Single request, data A5.
    req = 4'b0001;
    @(negedge clk);
    chk("t1_gnt",   32'(gnt), 32'h1);
    chk("t1_start", 32'(mst_start), 32'h1);
    chk("t1_cs_n",  32'(cs_n), 32'hE);
    chk("t1_data",  32'(mst_data), 32'hA5);
    chk("t1_busy",  32'(busy), 32'h1);
    req = 4'b0000;
    wait_ack1(4'b1110, 8'hA5, cyc, bad);
    chk("t1_ack_lat", 32'(cyc), 32'd11);
    chk("t1_cs_hold", 32'(bad), 32'h0);
    chk("t1_ack",     32'(ack), 32'h1);
    chk("t1_cs_rel",  32'(cs_n), 32'hF);
    chk("t1_mosi",    32'(rx), 32'hA5);

    // All four requesting from reset: 0,1,2,3,0 with CS_GAP+2 cycles ack->gnt.
    repeat (4) @(negedge clk);
    reset = 1'b1; @(negedge clk); reset = 1'b0; @(negedge clk);
    req = 4'hF;
    @(negedge clk);
    chk("t2_gnt0",  32'(gnt), 32'h1);
    chk("t2_data0", 32'(mst_data), 32'hA5);
    for (int k = 1; k <= 4; k++) begin
      oh    = 4'b0001 << ((k - 1) % 4);
      exp_b = req_data[((k - 1) % 4) * 8 +: 8];
      wait_ack1(~oh, exp_b, cyc, bad);
      chk("t2_ack",  32'(ack), 32'(oh));
      chk("t2_hold", 32'(bad), 32'h0);
      chk("t2_mosi", 32'(rx), 32'(exp_b));
      wait_gnt1(cyc, bad);
      oh    = 4'b0001 << (k % 4);
      exp_b = req_data[(k % 4) * 8 +: 8];
      chk("t2_ack_to_gnt", 32'(cyc), 32'd4);
      chk("t2_gap_cs",     32'(bad), 32'h0);
      chk("t2_gnt",        32'(gnt), 32'(oh));
      chk("t2_data",       32'(mst_data), 32'(exp_b));
    end
    req = 4'b0000;
    wait_ack1(4'b1110, 8'hA5, cyc, bad);
    chk("t2_last_ack", 32'(ack), 32'h1);

    // Serve 2 to move ptr to 3, then 2 and 3 together: 3 first, then 2.
    repeat (4) @(negedge clk);
    req = 4'b0100;
    @(negedge clk);
    chk("t3_pre_gnt", 32'(gnt), 32'h4);
    req = 4'b0000;
    wait_ack1(4'b1011, 8'h96, cyc, bad);
    repeat (4) @(negedge clk);
    req = 4'b1100;
    @(negedge clk);
    chk("t3_gnt3", 32'(gnt), 32'h8);
    req = 4'b0100;
    wait_ack1(4'b0111, 8'h3C, cyc, bad);
    chk("t3_hold3", 32'(bad), 32'h0);
    chk("t3_mosi3", 32'(rx), 32'h3C);
    wait_gnt1(cyc, bad);
    chk("t3_gnt2", 32'(gnt), 32'h4);
    req = 4'b0000;
    wait_ack1(4'b1011, 8'h96, cyc, bad);
    chk("t3_mosi2", 32'(rx), 32'h96);

    // Reset mid-WAIT: immediate release, no ack, then normal service.
    repeat (4) @(negedge clk);
    req = 4'b0010;
    @(negedge clk);
    chk("t4_gnt1", 32'(gnt), 32'h2);
    req = 4'b0000;
    repeat (3) @(negedge clk);
    chk("t4_cs_wait", 32'(cs_n), 32'hD);
    reset = 1'b1;
    #1;
    chk("t4_rst_cs",   32'(cs_n), 32'hF);
    chk("t4_rst_busy", 32'(busy), 32'h0);
    chk("t4_rst_ack",  32'(ack), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    seen  = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (ack !== 4'b0 || cs_n !== 4'hF) seen = 1'b1;
    end
    chk("t4_no_ack", 32'(seen), 32'h0);
    req = 4'b0100;
    @(negedge clk);
    chk("t4_gnt2", 32'(gnt), 32'h4);
    req = 4'b0000;
    wait_ack1(4'b1011, 8'h96, cyc, bad);
    chk("t4_lat",  32'(cyc), 32'd11);
    chk("t4_mosi", 32'(rx), 32'h96);

    // CS_GAP=0: back-to-back, next mst_start two cycles after ack.
    req2 = 4'b0011;
    @(negedge clk);
    chk("t5_gnt0", 32'(gnt2), 32'h1);
    req2 = 4'b0010;
    cyc  = 0;
    do begin @(negedge clk); cyc++; end while (ack2 === 4'b0 && cyc < 100);
    chk("t5_ack0", 32'(ack2), 32'h1);
    chk("t5_lat",  32'(cyc), 32'd11);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (mst_start2 !== 1'b1 && cyc < 100);
    chk("t5_restart", 32'(cyc), 32'd2);
    chk("t5_gnt1",    32'(gnt2), 32'h2);
    req2 = 4'b0000;

`ifdef SPI_TIMEOUT_EN
    // Timeout: done never arrives, err 16 cycles after WAIT entry.
    req3 = 4'b0001;
    @(negedge clk);
    chk("t6_gnt", 32'(gnt3), 32'h1);
    req3 = 4'b0000;
    cyc  = 0; seen = 1'b0;
    do begin
      @(negedge clk); cyc++;
      if (ack3 !== 4'b0) seen = 1'b1;
    end while (err3 !== 1'b1 && cyc < 100);
    chk("t6_err_lat", 32'(cyc), 32'd17);
    chk("t6_cs_rel",  32'(cs_n3), 32'hF);
    chk("t6_no_ack",  32'(seen), 32'h0);
    @(negedge clk);
    chk("t6_err_pulse", 32'(err3), 32'h0);
`endif

    chk("err_never", 32'(err_seen), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

endmodule
